// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and engine mode for the handshaked sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_ROL  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_SCO  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
// lo/hi present the result of the final step combinationally in the cycle done is high.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  // hi_reg/lo_reg form one double-width shift register: accumulator:multiplier
  // for MUL, partial remainder:dividend-becoming-quotient for DIVU.
  logic [WIDTH-1:0] hi_reg, lo_reg, opnd_reg;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  md_mode_t         mode_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    if (mode_reg == MD_MUL) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end else begin
      hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], div_ge};
    end
  end

  assign done = busy_reg && (cnt_reg == CW'(WIDTH - 1));
  assign lo   = lo_next;
  assign hi   = hi_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      opnd_reg <= '0;
      mode_reg <= MD_MUL;
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
      mode_reg <= mode;
      hi_reg   <= '0;
      lo_reg   <= (mode == MD_MUL) ? b : a;
      opnd_reg <= (mode == MD_MUL) ? a : b;
    end else if (busy_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle ops registered directly, MUL/DIVU through the
// iterative engine. One operation in flight; result held until the consumer takes it.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             dz
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] res_hi_reg, res_hi_next;
  logic             dz_reg, dz_next;

  logic             accept;
  logic             md_start;
  md_mode_t         md_mode;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [SH_W-1:0]    sh;
  logic [WIDTH:0]     add_full;
  logic [2*WIDTH-1:0] rol_wide, ror_wide;
  logic [WIDTH-1:0]   alu_res;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign res       = res_reg;
  assign res_hi    = res_hi_reg;
  assign dz        = dz_reg;
  assign accept    = in_valid && (state_reg == ST_IDLE);
  assign md_mode   = (op == OP_DIVU) ? MD_DIV : MD_MUL;

  // Rotates come from shifting a doubled copy of a and keeping one half.
  always_comb begin
    sh       = b[SH_W-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    rol_wide = {a, a} << sh;
    ror_wide = {a, a} >> sh;
    alu_res  = '0;
    case (op)
      OP_SUB:  alu_res = b - a;
      OP_XOR:  alu_res = a ^ b;
      OP_ANDN: alu_res = a & ~b;
      OP_ROL:  alu_res = rol_wide[2*WIDTH-1:WIDTH];
      OP_SLL:  alu_res = a << sh;
      OP_ROR:  alu_res = ror_wide[WIDTH-1:0];
      OP_SRL:  alu_res = a >> sh;
      OP_SEQ:  alu_res[0] = (a == b);
      OP_SLT:  alu_res[0] = ($signed(a) < $signed(b));
      OP_SLE:  alu_res[0] = ($signed(a) <= $signed(b));
      OP_SCO:  alu_res[0] = add_full[WIDTH];
      default: alu_res = add_full[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    res_next    = res_reg;
    res_hi_next = res_hi_reg;
    dz_next     = dz_reg;
    md_start    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          dz_next = 1'b0;
          if (is_multi(op)) begin
            if ((op == OP_DIVU) && (b == '0)) begin
              res_next    = '1;
              res_hi_next = a;
              dz_next     = 1'b1;
              state_next  = ST_DONE;
            end else begin
              md_start   = 1'b1;
              state_next = ST_ITER;
            end
          end else begin
            res_next    = alu_res;
            res_hi_next = '0;
            state_next  = ST_DONE;
          end
        end
      end
      ST_ITER: begin
        if (md_done) begin
          res_next    = md_lo;
          res_hi_next = md_hi;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      res_reg    <= '0;
      res_hi_reg <= '0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      res_reg    <= res_next;
      res_hi_reg <= res_hi_next;
      dz_reg     <= dz_next;
    end
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .mode  (md_mode),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It covers the same arithmetic, logic, shift/rotate and set-flag operations and adds iterative unsigned multiply and divide. Results are registered and come with valid/ready flow control, so the execute stage can stall on long operations. It sits in EX between the operand muxes (register/immediate already selected) and the EX/MEM pipeline register.

Parameters:
WIDTH, 16, datapath width in bits; power of two, >= 8
SH_W, $clog2(WIDTH), shift-amount width taken from b[SH_W-1:0]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation
op  in  4  operation code (package constants)
a  in  WIDTH  operand A (Rs, or ~Rs already applied upstream not required: SUB is native)
b  in  WIDTH  operand B (Rt or extended immediate)
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result
res  out  WIDTH  primary result (MUL low half, DIVU quotient)
res_hi  out  WIDTH  MUL high half, DIVU remainder; 0 for other ops
dz  out  1  divide-by-zero flag, valid with out_valid

Behaviour:
- Ops: ADD a+b; SUB b-a; XOR; ANDN a&~b; ROL; SLL; ROR; SRL; SEQ a==b; SLT/SLE signed a<b / a<=b; SCO carry-out of a+b; MUL unsigned; DIVU unsigned.
- Set ops return {WIDTH-1 zeros, bit}. Shifts use b[SH_W-1:0]. All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, ITER, DONE.
- in_ready = (state==IDLE). Accept occurs when in_valid & in_ready.
- IDLE + accept of a single-cycle op: res/res_hi computed and registered at the same edge; go to DONE. Latency: out_valid is high in the cycle after accept.
- IDLE + accept of MUL or DIVU with b!=0: operands latched, cnt=0, go to ITER.
- IDLE + accept of DIVU with b==0: res=all ones, res_hi=a, dz=1; go to DONE (1-cycle latency).
- ITER: one bit per cycle (shift-add multiply, restoring divide), cnt increments. When cnt==WIDTH-1, the final step writes res/res_hi and goes to DONE. Accept to out_valid = WIDTH+1 cycles (17 at default).
- DONE: out_valid=1. res, res_hi and dz are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid the next cycle.
- No overlap: a new op is never accepted in the cycle its result is consumed.
- in_valid/op/a/b are ignored outside IDLE. Operands need not be held after accept.
- Reset: when rst_n is low at an edge, the state goes to IDLE, cnt=0, out_valid=0, res=0, res_hi=0, dz=0. This holds from any state, including mid-ITER; the partial result is discarded. in_ready=1 from the first cycle after reset.
- dz clears to 0 on every accept.
- An unused op code behaves as ADD.

Decomposition:
- Package alu_seq_pkg:
  - 4-bit op constants: OP_ADD=0, OP_SUB=1, OP_XOR=2, OP_ANDN=3, OP_ROL=4, OP_SLL=5, OP_ROR=6, OP_SRL=7, OP_SEQ=8, OP_SLT=9, OP_SLE=10, OP_SCO=11, OP_MUL=12, OP_DIVU=13.
  - State encoding ST_IDLE/ST_ITER/ST_DONE.
  - Helper is_multi(op).
- Sub-module alu_seq_muldiv: iterative engine with start/mode/a/b in and done/lo/hi out, parametrised by WIDTH.
- The single-cycle ops and the FSM live in alu_seq.

Test Plan:
- OP_ADD a=0x7FFF b=0x0001 -> out_valid the cycle after accept, res=0x8000, res_hi=0. OP_SCO a=0xFFFF b=0x0001 -> res=0x0001.
- OP_MUL a=0x1234 b=0x0010 -> out_valid 17 cycles after accept, res=0x2340, res_hi=0x0001, in_ready=0 throughout.
- OP_DIVU a=100 b=7 -> res=14, res_hi=2, dz=0. DIVU a=0x00AB b=0 -> res=0xFFFF, res_hi=0x00AB, dz=1 one cycle after accept.
- OP_ROL a=0x8001 b=1 -> 0x0003. OP_SLT a=0xFFFF b=0x0001 -> 1. OP_SUB a=3 b=10 -> 7. Hold out_ready=0 for 5 cycles -> res stable and out_valid held, in_ready=0.
- Start MUL, drive rst_n=0 at ITER cycle 6 -> next cycle: out_valid=0, res=0, in_ready=1. A subsequent ADD 2+2 gives 4 with normal latency.
- WIDTH=32 build: MUL 0x00010000*0x00010000 -> res=0, res_hi=1, latency 33.
